// File: rtl/seg_mux_capture.sv
// ----------------------------------------------------------------------------
// seg_mux_capture
//
// Receive side of a six-digit multiplexed 7-segment display. The block samples
// the time-multiplexed segment bus and the active-low one-cold anode bus,
// waits for each bus state to settle, and rebuilds the six per-digit segment
// patterns. It also flags complete scan frames, anode protocol errors and a
// stalled scan.
//
// Optional feature (compile-time macro SEG_DECODE_EN):
//   defined   -> adds registered hex_out / hex_ok glyph decode of dig0..dig5
//   undefined -> those ports are absent; everything else is identical
//
// Parameters:
//   SETTLE   cycles {an_in,seg_in} must be stable before a capture (>= 2)
//   TIMEOUT  cycles without a capture before stale asserts (1 .. 2^24-1)
//   STALE_W  width of the stale counter
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   seg_in      segment bus, active-low, bit0=a .. bit6=g (asynchronous)
//   an_in       anode bus, active-low one-cold, bit k = digit k (asynchronous)
//   clear       synchronous clear of all captured state (wins over capture)
//   dig0..dig5  last captured pattern of each digit (7'h7F after reset)
//   dig_valid   bit k set once digit k has been captured since reset/clear
//   frame_done  one-cycle pulse per completed 0..5 scan frame
//   an_err      sticky: a settled anode pattern had more than one low bit
//   stale       high while no capture has happened for >= TIMEOUT cycles
//   hex_out     (SEG_DECODE_EN) nibble k = hex value of digk, 0 if no glyph
//   hex_ok      (SEG_DECODE_EN) bit k = digk is a valid 0-F glyph
// ----------------------------------------------------------------------------
module seg_mux_capture #(
   parameter int SETTLE  = 16,
   parameter int TIMEOUT = 1000000,
   parameter int STALE_W = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  seg_in,
   input  logic [5:0]  an_in,
   input  logic        clear,
   output logic [6:0]  dig0,
   output logic [6:0]  dig1,
   output logic [6:0]  dig2,
   output logic [6:0]  dig3,
   output logic [6:0]  dig4,
   output logic [6:0]  dig5,
   output logic [5:0]  dig_valid,
   output logic        frame_done,
   output logic        an_err,
   output logic        stale
`ifdef SEG_DECODE_EN
   ,
   output logic [23:0] hex_out,
   output logic [5:0]  hex_ok
`endif
);

   localparam int                 CNT_W     = $clog2(SETTLE + 1);
   localparam logic [CNT_W-1:0]   SETTLE_C  = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0]   SETTLE_M1 = CNT_W'(SETTLE - 1);
   localparam logic [STALE_W-1:0] TIMEOUT_C = STALE_W'(TIMEOUT);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,   // waiting for digit 0 to open a frame
      COLLECT = 2'd1,   // digit 0 seen, gathering digits 1..5
      DONE    = 2'd2    // all six digits seen, emit the frame pulse
   } state_t;

   // All architectural state in one record so that reset and clear share a
   // single definition of the idle values.
   typedef struct packed {
      logic [12:0]        sync1;      // first synchroniser stage {an,seg}
      logic [12:0]        s2;         // second synchroniser stage
      logic [12:0]        prev;       // s2 one cycle earlier
      logic [CNT_W-1:0]   cnt;        // stability counter, saturates at SETTLE
      logic [STALE_W-1:0] stale_cnt;  // cycles since last capture
      state_t             state;
      logic [5:0]         mask;       // digits seen in the current frame
      logic [5:0][6:0]    dig;
      logic [5:0]         dig_valid;
      logic               frame_done;
      logic               an_err;
      logic               stale;
   } regs_t;

   // NOTE: dig is a small register array, not a RAM; it is reset explicitly
   // because its outputs must read as blank (7'h7F) straight out of reset.
   localparam regs_t RESET_VAL = '{
      sync1:      13'd0,
      s2:         13'd0,
      prev:       13'd0,
      cnt:        '0,
      stale_cnt:  '0,
      state:      HUNT,
      mask:       6'd0,
      dig:        {6{7'h7F}},
      dig_valid:  6'd0,
      frame_done: 1'b0,
      an_err:     1'b0,
      stale:      1'b0
   };

   regs_t r;

   logic [5:0]         an_low;     // 1 = anode driven (active)
   logic [6:0]         seg_val;
   logic               one_low;
   logic               many_low;
   logic [2:0]         idx;
   logic               capture;
   logic [5:0]         mask_set;
   logic [STALE_W-1:0] stale_nxt;

   // Capture decode from the settled bus value.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and no latch is inferred.
      idx      = 3'd0;
      an_low   = ~r.s2[12:7];
      seg_val  = r.s2[6:0];
      one_low  = (an_low != 6'd0) && ((an_low & (an_low - 6'd1)) == 6'd0);
      many_low = (an_low != 6'd0) && !one_low;
      for (int k = 0; k < 6; k++) begin
         if (an_low[k]) idx = 3'(k);
      end
      // The counter sits at SETTLE-1 only once per stable episode, because it
      // keeps counting to SETTLE and then holds there.
      capture  = (r.s2 == r.prev) && (r.cnt == SETTLE_M1);
      mask_set = r.mask | (6'd1 << idx);

      if (capture)
         stale_nxt = '0;
      else if (r.stale_cnt != TIMEOUT_C)
         stale_nxt = r.stale_cnt + STALE_W'(1);
      else
         stale_nxt = r.stale_cnt;
   end

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r <= RESET_VAL;
      end else if (clear) begin
         // A capture on this same edge is dropped along with everything else.
         r <= RESET_VAL;
      end else begin
         r.sync1 <= {an_in, seg_in};
         r.s2    <= r.sync1;
         r.prev  <= r.s2;

         if (r.s2 != r.prev)
            r.cnt <= '0;
         else if (r.cnt != SETTLE_C)
            r.cnt <= r.cnt + CNT_W'(1);

         r.stale_cnt  <= stale_nxt;
         r.stale      <= (stale_nxt == TIMEOUT_C);
         r.frame_done <= 1'b0;

         // All-off patterns are captures too (they feed the stale counter)
         // but change nothing else.
         if (capture && one_low) begin
            r.dig[idx]       <= seg_val;
            r.dig_valid[idx] <= 1'b1;
         end
         if (capture && many_low)
            r.an_err <= 1'b1;

         unique case (r.state)
            HUNT: begin
               if (capture && one_low && idx == 3'd0) begin
                  r.mask  <= 6'd1;
                  r.state <= COLLECT;
               end
            end
            COLLECT: begin
               if (capture && one_low) begin
                  if (idx == 3'd0) begin
                     // Digit 0 again before the frame closed: start over.
                     r.mask <= 6'd1;
                  end else begin
                     r.mask <= mask_set;
                     if (mask_set == 6'h3F) r.state <= DONE;
                  end
               end
            end
            DONE: begin
               // Captures are at least SETTLE+1 cycles apart, so none can
               // land in this single cycle.
               r.frame_done <= 1'b1;
               r.mask       <= 6'd0;
               r.state      <= HUNT;
            end
            default: r.state <= HUNT;
         endcase
      end
   end

   assign dig0       = r.dig[0];
   assign dig1       = r.dig[1];
   assign dig2       = r.dig[2];
   assign dig3       = r.dig[3];
   assign dig4       = r.dig[4];
   assign dig5       = r.dig[5];
   assign dig_valid  = r.dig_valid;
   assign frame_done = r.frame_done;
   assign an_err     = r.an_err;
   assign stale      = r.stale;

`ifdef SEG_DECODE_EN
   // Returns {match, nibble} for an active-low glyph; unknown -> {0, 0}.
   function automatic logic [4:0] glyph_decode(input logic [6:0] p);
      unique case (p)
         7'h40:   return {1'b1, 4'h0};
         7'h79:   return {1'b1, 4'h1};
         7'h24:   return {1'b1, 4'h2};
         7'h30:   return {1'b1, 4'h3};
         7'h19:   return {1'b1, 4'h4};
         7'h12:   return {1'b1, 4'h5};
         7'h02:   return {1'b1, 4'h6};
         7'h78:   return {1'b1, 4'h7};
         7'h00:   return {1'b1, 4'h8};
         7'h10:   return {1'b1, 4'h9};
         7'h08:   return {1'b1, 4'hA};
         7'h03:   return {1'b1, 4'hB};
         7'h46:   return {1'b1, 4'hC};
         7'h21:   return {1'b1, 4'hD};
         7'h06:   return {1'b1, 4'hE};
         7'h0E:   return {1'b1, 4'hF};
         default: return 5'd0;
      endcase
   endfunction

   // Registered decode: follows the digit registers by one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hex_out <= '0;
         hex_ok  <= '0;
      end else if (clear) begin
         hex_out <= '0;
         hex_ok  <= '0;
      end else begin
         for (int k = 0; k < 6; k++) begin
            {hex_ok[k], hex_out[4*k +: 4]} <= glyph_decode(r.dig[k]);
         end
      end
   end
`endif

endmodule
